uart_receive_engine: RTL
========================

// Module: uart_receive_engine
// PURPOSE
//  UART receive side paired with the transmit engine; same eight/pen/ohel/k programming.
//  Oversamples the serial line with a k-cycle bit timer and samples mid-bit.
//  Deserialises 7/8 data bits plus optional parity, checks parity and stop bit.
//  Presents rx_data with a sticky rxrdy flag, cleared by the processor's read strobe.
// PARAMETERS
//  K_W   19  width of bit-time count k (clk cycles per bit)
// PORTS
//  clk        in   1    system clock
//  rst        in   1    reset; asynchronous, active-high
//  rx         in   1    async serial input, idle high
//  eight      in   1    1 = 8 data bits, 0 = 7
//  pen        in   1    parity enable
//  ohel       in   1    1 = odd parity, 0 = even
//  k          in   K_W  clk cycles per bit; held static during a frame
//  rd_clr     in   1    1-cycle read strobe: clears rxrdy, perr, ferr, ovf
//  rx_data    out  8    received byte; bit7 = 0 in 7-bit mode
//  rxrdy      out  1    new frame available (sticky)
//  perr       out  1    parity error on the frame in rx_data (sticky)
//  ferr       out  1    stop bit sampled 0 (sticky)
//  ovf        out  1    overrun (see CONFIGURATION)
// BEHAVIOUR
//  Reset: rx_data=0, rxrdy=perr=ferr=ovf=0, state IDLE, sync flops=1, counters=0.
//  rx passes through 2-flop synchroniser (rxs); all decisions use rxs.
//  btu = (bit_time_count == target); counter clears on btu or in IDLE, else +1.
//  target = k>>1 in START, k in DATA; k=0 gives btu every cycle.
//  nbits = 7 + eight + pen + 1 (bits after start: data, parity, stop; 8..10).
//  FSM:
//   IDLE : rxs==0 -> START, bit counter=0, timer cleared.
//   START: on btu: rxs==0 -> DATA; rxs==1 -> IDLE (false start, no flags).
//   DATA : on btu: sr <= {rxs, sr[9:1]}, bit counter+1;
//          when bit counter reaches nbits (stop bit sampled) -> DONE.
//   DONE : one cycle: load outputs, -> IDLE; next start may be seen next cycle.
//  Alignment: frame = sr >> (10-nbits); d = eight ? f[7:0] : {1'b0,f[6:0]};
//   pbit = f[7+eight]; stop = f[nbits-1].
//  Parity: ep = ^d, op = ~^d; perr <= pen & (pbit != (ohel ? op : ep)).
//  ferr <= ~stop. rxrdy <= 1. All three loaded in DONE.
//  rd_clr in same cycle as DONE: DONE wins (rxrdy=1, new flags); else rd_clr clears flags.
//  rxrdy rises 2 clks after the stop-bit mid-sample (DONE cycle + register).
//  Reset mid-frame: abort immediately, outputs to reset values.
//  rx stuck low: one frame with ferr=1, then re-enters START repeatedly (break).
// CONFIGURATION
//  UART_RX_OVERRUN_EN defined: in DONE, if rxrdy==1 and no rd_clr that cycle,
//   ovf <= 1; rx_data still overwritten; ovf cleared only by rd_clr/rst.
//  Undefined: ovf tied 0; new frame silently overwrites.
// STRUCTURE
//  Package uart_pkg: rx FSM state enum (IDLE/START/DATA/DONE), K_W,
//   SR_W=10, frame length constants (min 8, max 10 post-start bits).
//  Sub-module uart_rx_bit_timer: counter + btu compare, inputs clr/target.
//  Top holds synchroniser, FSM, shift register, bit counter, checks, flags.
// TESTING
//  k=8, 8N1, send 0x41 -> rx_data=0x41, rxrdy=1, perr=0, ferr=0; rd_clr -> rxrdy=0.
//  k=8, 7E1 (eight=0,pen=1,ohel=0), send 0x55 parity 0 -> rx_data=0x55, perr=0;
//   same with parity 1 -> perr=1.
//  k=8, 8O1, send 0xA5 parity 1 -> perr=0; stop bit forced 0 -> ferr=1.
//  k=8, rx low pulse 2 clks in IDLE -> no rxrdy, FSM back in IDLE.
//  two 8N1 frames 0x11, 0x22 without rd_clr -> rx_data=0x22; ovf=1 only with
//   UART_RX_OVERRUN_EN, else 0; rd_clr coincident with 2nd DONE -> ovf=0.
//  assert rst during data bit 3 -> all outputs 0 next cycle; next frame received clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive engine.
// Optional build macro: UART_RX_OVERRUN_EN (see uart_receive_engine.sv).
package uart_pkg;

  // Width of the bit-time count k (clk cycles per bit).
  localparam int K_W = 19;

  // Shift register width: largest number of post-start bits captured.
  localparam int SR_W = 10;

  // Post-start bit counts: 7 data + stop (min) up to 8 data + parity + stop (max).
  localparam int FRAME_MIN = 8;
  localparam int FRAME_MAX = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer: counts clk cycles and flags btu when the count hits target.
// The counter restarts on btu or while clr is held, so one bit period is
// target+1 cycles and target=0 yields btu on every cycle.
module uart_rx_bit_timer
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [K_W-1:0] target,
  output logic           btu
);

  logic [K_W-1:0] count;

  assign btu = (count == target);

  // Free-running cycle counter, restarted by clr or on reaching target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || btu) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receive_engine.sv
// UART receive engine: synchronises rx, finds the start bit, samples each
// bit at mid-bit, checks parity and stop, and presents a sticky result.
// Optional build macro: UART_RX_OVERRUN_EN enables the overrun flag (ovf);
// without it ovf is tied low and a new frame silently overwrites rx_data.
//
// Read handshake: rxrdy rises when a frame has been loaded into rx_data and
// stays high until a one-cycle rd_clr pulse; rd_clr also clears perr, ferr
// and ovf. If rd_clr coincides with the cycle a new frame is loaded, the
// new frame wins: rxrdy stays high and the flags describe the new frame.
// The FSM state is exposed on the state output for observation.
module uart_receive_engine
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic           eight,
  input  logic           pen,
  input  logic           ohel,
  input  logic [K_W-1:0] k,
  input  logic           rd_clr,
  output logic [7:0]     rx_data,
  output logic           rxrdy,
  output logic           perr,
  output logic           ferr,
  output logic           ovf,
  output rx_state_e      state
);

  logic            rx_meta;
  logic            rxs;
  logic            btu;
  logic [K_W-1:0]  target;
  logic [3:0]      bit_cnt;
  logic [3:0]      nbits;
  logic [3:0]      shamt;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] frame;
  logic [7:0]      d;
  logic            pbit;
  logic            stop;
  logic            parity_bad;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Half a bit to reach the middle of the start bit, then whole bits.
  assign target = (state == START) ? (k >> 1) : k;

  uart_rx_bit_timer u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .target (target),
    .btu    (btu)
  );

  // Post-start bits: data bits, optional parity, stop.
  assign nbits = 4'(FRAME_MIN) + {3'b000, eight} + {3'b000, pen};

  // Bits enter at the top of sr, so a short frame sits high; right-justify it.
  assign shamt      = 4'(SR_W) - nbits;
  assign frame      = sr >> shamt;
  assign d          = eight ? frame[7:0] : {1'b0, frame[6:0]};
  assign pbit       = eight ? frame[8] : frame[7];
  assign stop       = frame[nbits - 4'd1];
  assign parity_bad = pen & (pbit != (ohel ? ~^d : ^d));

  // Receive FSM plus the result registers it loads at the end of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          // A line that is high again at mid start bit was a glitch.
          if (btu) state <= rxs ? IDLE : DATA;
        end
        DATA: begin
          if (btu) begin
            sr      <= {rxs, sr[SR_W-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt + 4'd1 == nbits) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (state == DONE) begin
        rx_data <= d;
        rxrdy   <= 1'b1;
        perr    <= parity_bad;
        ferr    <= ~stop;
      end else if (rd_clr) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_OVERRUN_EN
  // Overrun: a frame landed while the previous one was still unread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (rd_clr) begin
      ovf <= 1'b0;
    end else if (state == DONE && rxrdy) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
